vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
- Top-level sequencer for the cola vending machine.
- Accumulates coin credit in half-yuan units and arbitrates a two-product selection.
- Drives a product dispenser, then a change hopper, each through a req/ack handshake; returns unspent credit on cancel or inactivity timeout.
- Sits between the coin acceptor/keypad front end and the dispenser/hopper mechanics.

Parameters:
- CREDIT_W, 4: width of credit register, in half-yuan units.
- MAX_CREDIT, 8: maximum accepted credit (4 yuan); must be < 2**CREDIT_W.
- PRICE_A, 5: product A price in half-yuan units (2.5 yuan).
- PRICE_B, 3: product B price in half-yuan units (1.5 yuan).
- TIMEOUT_CYC, 1000: idle cycles in COLLECT before automatic refund.
- STOCK_INIT, 15: initial stock per product (STOCK_CNT_EN only); 4-bit counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_yuan  in  1  one-cycle pulse, 1 yuan inserted (+2 units)
- in_jiao  in  1  one-cycle pulse, 0.5 yuan inserted (+1 unit)
- sel_valid  in  1  one-cycle selection strobe
- sel_id  in  1  0 = product A, 1 = product B
- cancel  in  1  one-cycle refund request
- disp_ack  in  1  dispenser done
- hopper_ack  in  1  hopper coin ejected
- disp_req  out  1  dispense request
- disp_sel  out  1  product being dispensed
- hopper_req  out  1  eject-one-coin request
- hopper_coin  out  1  1 = eject 1 yuan, 0 = eject 0.5 yuan
- coin_reject  out  1  one-cycle pulse: coin(s) routed to return chute
- sel_err  out  1  one-cycle pulse: selection refused
- credit  out  CREDIT_W  current credit
- state  out  3  FSM state, for display/debug
- sold_out  out  2  [0]=A, [1]=B; STOCK_CNT_EN only

Behaviour:
- Reset: state=IDLE(0); credit=0; all outputs 0. Reset mid-handshake drops disp_req/hopper_req immediately; credit is lost.
- States: IDLE=0, COLLECT=1, VEND=2, CHANGE=3.
- Coin accept, in IDLE/COLLECT only:
  - add = 2*in_yuan + in_jiao; both pulses in one cycle add 3.
  - If credit+add <= MAX_CREDIT: credit += add, registered one cycle later.
  - Otherwise all coins that cycle are rejected: coin_reject=1 next cycle, credit unchanged.
- Any coin in VEND/CHANGE is rejected (coin_reject pulse).
- IDLE: credit becomes nonzero -> COLLECT.
- COLLECT, priority cancel > timeout > sel_valid:
  - Timeout counter clears on any accepted coin or refused selection; reaching TIMEOUT_CYC -> CHANGE.
  - cancel -> CHANGE.
  - sel_valid with registered credit >= price(sel_id) -> VEND; disp_sel latched.
  - sel_valid with credit < price -> sel_err pulse, stay.
  - A coin arriving with sel_valid is still added; the price check uses pre-coin credit.
- VEND:
  - disp_req=1 held until disp_ack sampled high.
  - In that cycle credit -= price; disp_req drops next cycle.
  - Next state: CHANGE if remaining credit > 0, else IDLE.
- CHANGE:
  - hopper_coin = (credit >= 2). hopper_req held until hopper_ack sampled high.
  - On ack: credit -= 2 or 1; hopper_req deasserts for one cycle, then re-asserts if credit > 0.
  - credit = 0 -> IDLE.
- Handshakes: ack sampled while the matching req is low is ignored. sel_valid/cancel outside COLLECT are ignored (no sel_err).
- No wrap-around: credit is never decremented below 0 nor above MAX_CREDIT.

Optional Feature:
- STOCK_CNT_EN defined:
  - Per-product 4-bit stock counters load STOCK_INIT at reset and decrement on disp_ack.
  - sold_out[i] = (stock_i == 0).
  - Selecting a sold-out product -> sel_err pulse, stays COLLECT.
- Undefined: sold_out port and counters absent; stock is unlimited.

Test Plan:
- in_yuan, in_yuan, in_jiao, sel A (price 5) -> disp_req, disp_sel=0; on ack credit 5->0, state IDLE, no hopper_req.
- in_yuan x4, sel B -> vend B; credit 8->5; hopper ejects yuan, yuan, half (hopper_coin 1,1,0); end IDLE with credit 0.
- in_yuan+in_jiao same cycle -> credit=3. Then in_yuan x3: first two accepted (credit 7), third gives coin_reject (9 > 8).
- credit=3, sel A -> sel_err pulse, credit stays 3. Then cancel -> hopper yuan then half, IDLE.
- credit=2, no activity for TIMEOUT_CYC cycles -> CHANGE, one yuan refunded. Repeat with rst asserted during hopper_req -> all outputs 0 at once.
- With STOCK_CNT_EN, STOCK_INIT=1: two A purchases -> sold_out[0]=1 after the first; second sel A -> sel_err, credit retained.

Source files
------------

// File: rtl/vend_ctrl_if.sv
// vend_ctrl_if: front-end / mechanics signal bundle for the vending sequencer.
// master = coin acceptor, keypad and mechanics side; slave = vend_ctrl.
// sold_out exists only when STOCK_CNT_EN is defined.
interface vend_ctrl_if #(
    parameter int CREDIT_W = 4
);
    logic                in_yuan;
    logic                in_jiao;
    logic                sel_valid;
    logic                sel_id;
    logic                cancel;
    logic                disp_ack;
    logic                hopper_ack;
    logic                disp_req;
    logic                disp_sel;
    logic                hopper_req;
    logic                hopper_coin;
    logic                coin_reject;
    logic                sel_err;
    logic [CREDIT_W-1:0] credit;
    logic [2:0]          state;
`ifdef STOCK_CNT_EN
    logic [1:0]          sold_out;
`endif

    modport master (
        output in_yuan, in_jiao, sel_valid, sel_id, cancel, disp_ack, hopper_ack,
        input  disp_req, disp_sel, hopper_req, hopper_coin, coin_reject, sel_err,
               credit, state
`ifdef STOCK_CNT_EN
        , input sold_out
`endif
    );

    modport slave (
        input  in_yuan, in_jiao, sel_valid, sel_id, cancel, disp_ack, hopper_ack,
        output disp_req, disp_sel, hopper_req, hopper_coin, coin_reject, sel_err,
               credit, state
`ifdef STOCK_CNT_EN
        , output sold_out
`endif
    );
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: cola vending machine sequencer.
// Collects credit in half-yuan units, arbitrates a two-product selection,
// drives the dispenser and change hopper through req/ack handshakes and
// refunds credit on cancel or inactivity timeout.
// Optional feature macro: STOCK_CNT_EN (per-product stock counters, sold_out).
module vend_ctrl #(
  parameter int CREDIT_W    = 4,
  parameter int MAX_CREDIT  = 8,
  parameter int PRICE_A     = 5,
  parameter int PRICE_B     = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int STOCK_INIT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_yuan,
  input  logic                in_jiao,
  input  logic                sel_valid,
  input  logic                sel_id,
  input  logic                cancel,
  input  logic                disp_ack,
  input  logic                hopper_ack,
  output logic                disp_req,
  output logic                disp_sel,
  output logic                hopper_req,
  output logic                hopper_coin,
  output logic                coin_reject,
  output logic                sel_err,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state
`ifdef STOCK_CNT_EN
  , output logic [1:0]        sold_out
`endif
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VEND    = 3'd2,
    CHANGE  = 3'd3
  } state_t;

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CREDIT_W:0]   MAX_EXT  = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PA       = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB       = CREDIT_W'(PRICE_B);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                disp_sel_q, disp_sel_d;
  logic                gap_q, gap_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_err_q, sel_err_d;

  logic [1:0]          coin_add;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_any;
  logic                coin_ok;
  logic                hopper_req_w;
  logic                hopper_coin_w;
  logic                sel_sold;

  function automatic logic [CREDIT_W-1:0] price_of(input logic id);
    return id ? PB : PA;
  endfunction

`ifdef STOCK_CNT_EN
  logic [3:0] stock_a, stock_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stock_a <= 4'(STOCK_INIT);
      stock_b <= 4'(STOCK_INIT);
    end else if (state_q == VEND && disp_ack) begin
      if (!disp_sel_q && stock_a != '0) stock_a <= stock_a - 4'd1;
      if ( disp_sel_q && stock_b != '0) stock_b <= stock_b - 4'd1;
    end
  end

  assign sold_out = {(stock_b == '0), (stock_a == '0)};
  assign sel_sold = sel_id ? (stock_b == '0) : (stock_a == '0);
`else
  assign sel_sold = 1'b0;
`endif

  assign coin_add = {in_yuan, in_jiao};
  assign coin_any = in_yuan | in_jiao;
  assign coin_sum = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_add};
  assign coin_ok  = coin_any && (coin_sum <= MAX_EXT);

  assign hopper_req_w  = (state_q == CHANGE) && !gap_q && (credit_q != '0);
  assign hopper_coin_w = (state_q == CHANGE) && (credit_q >= CREDIT_W'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      timer_q       <= '0;
      disp_sel_q    <= 1'b0;
      gap_q         <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      timer_q       <= timer_d;
      disp_sel_q    <= disp_sel_d;
      gap_q         <= gap_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    timer_d       = '0;
    disp_sel_d    = disp_sel_q;
    gap_d         = 1'b0;
    coin_reject_d = 1'b0;
    sel_err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (coin_ok)       credit_d      = coin_sum[CREDIT_W-1:0];
        else if (coin_any) coin_reject_d = 1'b1;
        if (credit_d != '0) state_d = COLLECT;
      end

      COLLECT: begin
        timer_d = timer_q + TMR_W'(1);
        if (coin_ok) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          timer_d  = '0;
        end else if (coin_any) begin
          coin_reject_d = 1'b1;
        end

        if (cancel || timer_q == TMR_LAST) begin
          state_d = CHANGE;
          timer_d = '0;
        end else if (sel_valid) begin
          if (sel_sold || credit_q < price_of(sel_id)) begin
            sel_err_d = 1'b1;
            timer_d   = '0;
          end else begin
            state_d    = VEND;
            disp_sel_d = sel_id;
            timer_d    = '0;
          end
        end
      end

      VEND: begin
        if (coin_any) coin_reject_d = 1'b1;
        if (disp_ack) begin
          credit_d = credit_q - price_of(disp_sel_q);
          state_d  = (credit_d != '0) ? CHANGE : IDLE;
        end
      end

      CHANGE: begin
        if (coin_any) coin_reject_d = 1'b1;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (hopper_req_w && hopper_ack) begin
          credit_d = credit_q - (hopper_coin_w ? CREDIT_W'(2) : CREDIT_W'(1));
          gap_d    = 1'b1;
          if (credit_d == '0) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign disp_req    = (state_q == VEND);
  assign disp_sel    = disp_sel_q;
  assign hopper_req  = hopper_req_w;
  assign hopper_coin = hopper_coin_w;
  assign coin_reject = coin_reject_q;
  assign sel_err     = sel_err_q;
  assign credit      = credit_q;
  assign state       = state_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed-vector bench for vend_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vend_ctrl;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic       in_yuan, in_jiao, sel_valid, sel_id, cancel, disp_ack, hopper_ack;
  logic       disp_req, disp_sel, hopper_req, hopper_coin, coin_reject, sel_err;
  logic [3:0] credit;
  logic [2:0] state;
`ifdef STOCK_CNT_EN
  logic [1:0] sold_out;
`endif

  always #5 clk = ~clk;

  vend_ctrl #(
    .CREDIT_W(4), .MAX_CREDIT(8), .PRICE_A(5), .PRICE_B(3),
    .TIMEOUT_CYC(TMO), .STOCK_INIT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_yuan(in_yuan), .in_jiao(in_jiao), .sel_valid(sel_valid), .sel_id(sel_id),
    .cancel(cancel), .disp_ack(disp_ack), .hopper_ack(hopper_ack),
    .disp_req(disp_req), .disp_sel(disp_sel), .hopper_req(hopper_req),
    .hopper_coin(hopper_coin), .coin_reject(coin_reject), .sel_err(sel_err),
    .credit(credit), .state(state)
`ifdef STOCK_CNT_EN
    , .sold_out(sold_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic coin(input logic y, input logic j);
    in_yuan = y; in_jiao = j;
    step();
    in_yuan = 1'b0; in_jiao = 1'b0;
  endtask

  task automatic sel(input logic id);
    sel_valid = 1'b1; sel_id = id;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic cancel_pulse();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  task automatic disp_ack_pulse();
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
  endtask

  task automatic hop_ack_pulse();
    hopper_ack = 1'b1;
    step();
    hopper_ack = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int unsigned n = 0; n < 40 && state != 3'd0; n++) begin
      hopper_ack = hopper_req;
      step();
      hopper_ack = 1'b0;
    end
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_credit"}, 32'(credit), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_yuan = 0; in_jiao = 0; sel_valid = 0; sel_id = 0;
    cancel = 0; disp_ack = 0; hopper_ack = 0;
    step(); step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_outs", 32'({disp_req, hopper_req, coin_reject, sel_err}), 32'd0);
    rst = 1'b0;
    step();

    sel(1'b1);
    chk("idle_sel_err", 32'(sel_err), 32'd0);
    chk("idle_sel_state", 32'(state), 32'd0);
    cancel_pulse();
    chk("idle_cancel_state", 32'(state), 32'd0);

    coin(1, 0);
    chk("t1_credit2", 32'(credit), 32'd2);
    chk("t1_collect", 32'(state), 32'd1);
    coin(1, 0);
    coin(0, 1);
    chk("t1_credit5", 32'(credit), 32'd5);
    sel(1'b0);
    chk("t1_vend", 32'(state), 32'd2);
    chk("t1_disp_req", 32'(disp_req), 32'd1);
    chk("t1_disp_sel", 32'(disp_sel), 32'd0);
    step();
    chk("t1_req_held", 32'(disp_req), 32'd1);
    disp_ack_pulse();
    chk("t1_credit0", 32'(credit), 32'd0);
    chk("t1_idle", 32'(state), 32'd0);
    chk("t1_no_disp_req", 32'(disp_req), 32'd0);
    chk("t1_no_hopper", 32'(hopper_req), 32'd0);
`ifdef STOCK_CNT_EN
    chk("stk_sold_a", 32'(sold_out), 32'd1);
`endif

    repeat (4) coin(1, 0);
    chk("t2_credit8", 32'(credit), 32'd8);
    sel(1'b1);
    chk("t2_disp_sel", 32'(disp_sel), 32'd1);
    disp_ack_pulse();
    chk("t2_credit5", 32'(credit), 32'd5);
    chk("t2_change", 32'(state), 32'd3);
    chk("t2_hreq1", 32'(hopper_req), 32'd1);
    chk("t2_coin1", 32'(hopper_coin), 32'd1);
    hop_ack_pulse();
    chk("t2_credit3", 32'(credit), 32'd3);
    chk("t2_gap", 32'(hopper_req), 32'd0);
    hop_ack_pulse();
    chk("t2_ign_credit", 32'(credit), 32'd3);
    chk("t2_hreq2", 32'(hopper_req), 32'd1);
    chk("t2_coin2", 32'(hopper_coin), 32'd1);
    hop_ack_pulse();
    chk("t2_credit1", 32'(credit), 32'd1);
    step();
    chk("t2_hreq3", 32'(hopper_req), 32'd1);
    chk("t2_coin3", 32'(hopper_coin), 32'd0);
    hop_ack_pulse();
    chk("t2_credit0", 32'(credit), 32'd0);
    chk("t2_idle", 32'(state), 32'd0);
    chk("t2_hreq_off", 32'(hopper_req), 32'd0);

    coin(1, 1);
    chk("t3_credit3", 32'(credit), 32'd3);
    coin(1, 0);
    coin(1, 0);
    chk("t3_credit7", 32'(credit), 32'd7);
    chk("t3_no_rej", 32'(coin_reject), 32'd0);
    coin(1, 0);
    chk("t3_reject", 32'(coin_reject), 32'd1);
    chk("t3_credit_kept", 32'(credit), 32'd7);
    coin(0, 1);
    chk("t3_rej_pulse", 32'(coin_reject), 32'd0);
    chk("t3_credit_max", 32'(credit), 32'd8);
    cancel_pulse();
    drain("t3");

    coin(1, 1);
    sel(1'b0);
    chk("t4_sel_err", 32'(sel_err), 32'd1);
    chk("t4_credit3", 32'(credit), 32'd3);
    chk("t4_collect", 32'(state), 32'd1);
    step();
    chk("t4_err_pulse", 32'(sel_err), 32'd0);
    cancel_pulse();
    chk("t4_change", 32'(state), 32'd3);
    chk("t4_coin1", 32'(hopper_coin), 32'd1);
    hop_ack_pulse();
    chk("t4_credit1", 32'(credit), 32'd1);
    coin(0, 1);
    chk("t4_chg_reject", 32'(coin_reject), 32'd1);
    chk("t4_chg_credit", 32'(credit), 32'd1);
    chk("t4_coin_half", 32'(hopper_coin), 32'd0);
    hop_ack_pulse();
    chk("t4_idle", 32'(state), 32'd0);
    chk("t4_credit0", 32'(credit), 32'd0);

    coin(1, 0);
    repeat (TMO - 1) step();
    chk("t5_before_tmo", 32'(state), 32'd1);
    step();
    chk("t5_tmo_change", 32'(state), 32'd3);
    chk("t5_hreq", 32'(hopper_req), 32'd1);
    chk("t5_coin", 32'(hopper_coin), 32'd1);
    hop_ack_pulse();
    chk("t5_idle", 32'(state), 32'd0);
    chk("t5_credit0", 32'(credit), 32'd0);

    coin(1, 0);
    repeat (TMO) step();
    chk("t6_hreq", 32'(hopper_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_hreq", 32'(hopper_req), 32'd0);
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_credit", 32'(credit), 32'd0);
    step();
    rst = 1'b0;
    step();

`ifdef STOCK_CNT_EN
    chk("stk_reload", 32'(sold_out), 32'd0);
    coin(1, 0); coin(1, 0); coin(0, 1);
    sel(1'b0);
    disp_ack_pulse();
    chk("stk_sold_a2", 32'(sold_out), 32'd1);
    coin(1, 0); coin(1, 0); coin(0, 1);
    sel(1'b0);
    chk("stk_sel_err", 32'(sel_err), 32'd1);
    chk("stk_credit", 32'(credit), 32'd5);
    chk("stk_collect", 32'(state), 32'd1);
    cancel_pulse();
    drain("stk");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
